irq_arbiter: RTL
================

Name: irq_arbiter

Overview:
Hardware interrupt controller in front of cp0. It synchronises N_IRQ external interrupt lines and latches their rising edges into a pending register. It applies a software-writable mask and selects one fixed-priority winner. That winner is presented to cp0 as a one-hot hardware_interrupt vector, held until cp0 acknowledges it and the handler returns via eret. Single-level, no nesting.

Parameters:
N_IRQ, 8, number of interrupt lines; also the width of hardware_interrupt into cp0.
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (at least 2).
GAP_CYCLES, 2, idle cycles enforced after eret before the next request may be presented (at least 0).

Ports:
clk  in  1  system clock.
clr  in  1  asynchronous active-high reset.
irq_in  in  N_IRQ  raw external interrupt lines, asynchronous to clk.
mask_we  in  1  write strobe for the mask register.
mask_wdata  in  N_IRQ  new mask value; bit=1 enables that line.
ack  in  1  one-cycle pulse from cp0 when it takes the interrupt.
eret  in  1  one-cycle pulse when eret executes.
hardware_interrupt  out  N_IRQ  one-hot request to cp0; all zeros when nothing is requested.
irq_id  out  $clog2(N_IRQ)  index of the line being requested or serviced.
busy  out  1  high in REQ and SERVICE.
pending  out  N_IRQ  latched pending bits, before masking.
irq_mask  out  N_IRQ  current mask.

Behaviour:
- Reset (async, clr=1): all outputs and registers are zero. State=IDLE, pending=0, irq_mask=0 (all lines disabled), sync chains=0, gap counter=0. A clr asserted mid-service aborts immediately, with no ack or eret needed.
- Synchroniser and edge detect:
  - irq_in[i] first sampled high at posedge k reaches the last sync stage at posedge k+SYNC_STAGES-1.
  - pending[i] sets at posedge k+SYNC_STAGES on the 0->1 transition of the last stage.
  - A level held high sets pending only once. Pulses shorter than one clk period may be lost (documented limitation).
- Pending set/clear:
  - pending[i] clears on the cycle ack is accepted for i.
  - A new edge on i in that same cycle wins: pending[i] stays 1.
  - Edges while already pending are not counted.
- Mask:
  - On mask_we, irq_mask <= mask_wdata at the next posedge.
  - eligible = pending & irq_mask.
  - Winner = lowest set index of eligible; index 0 is highest priority.
- FSM states: IDLE, REQ, SERVICE, GAP.
  - IDLE -> REQ when eligible≠0 and gap counter=0. irq_id latches the winner. hardware_interrupt = 1<<irq_id, registered, visible the cycle after entering REQ decision. End-to-end: irq_in high at posedge k gives hardware_interrupt asserted after posedge k+SYNC_STAGES+1.
  - REQ holds irq_id fixed. A higher-priority line arriving does not preempt.
  - REQ -> SERVICE on ack: pending[irq_id] clears and hardware_interrupt goes to 0 at the same posedge.
  - REQ -> IDLE if irq_mask[irq_id] becomes 0 with no ack that cycle. The request is withdrawn; pending stays set.
  - If ack and a mask-off occur together, ack wins.
  - SERVICE -> GAP on eret. The gap counter loads GAP_CYCLES. If GAP_CYCLES=0, go directly to IDLE.
  - GAP decrements each cycle and goes to IDLE when it reaches 0.
  - eret in IDLE, REQ or GAP is ignored. ack outside REQ is ignored.
  - Edges and mask writes are accepted in every state.
- busy=1 in REQ and SERVICE only.
- irq_id holds its last value in IDLE and GAP. It is meaningful only while busy.

Decomposition:
- defines.vh gets the IRQ_STATE_IDLE/REQ/SERVICE/GAP 2-bit encodings and the IRQ_DEFAULT_N constant.
- One natural sub-module, irq_sync: a per-line SYNC_STAGES synchroniser plus rising-edge detector, producing a single-cycle edge pulse. It is instantiated N_IRQ times via generate.
- Priority encoder, FSM and gap counter stay in irq_arbiter.

Test Plan:
- Reset: clr=1 mid-REQ with irq_mask=8'hFF, pending=8'h05 -> all outputs 0 asynchronously, state IDLE after release.
- Basic: irq_mask=8'hFF; irq_in[3] rises sampled at posedge k -> pending=8'h08 after k+2, hardware_interrupt=8'h08 and irq_id=3 after k+3. ack -> hardware_interrupt=0, pending=0, busy=1. eret -> busy=0; with irq_in[5] edge before the eret, no request for 2 cycles (GAP), then hardware_interrupt=8'h20.
- Priority/no preemption: lines 6 and 2 rise together -> irq_id=2. Line 0 rises during REQ -> irq_id stays 2. After eret+gap -> irq_id=0, then 6.
- Mask: irq_mask=8'h00, irq_in[1] edge -> pending=8'h02, no request. Write mask 8'h02 -> request 8'h02. In REQ write mask 8'h00 -> request withdrawn, pending stays 8'h02.
- Re-arm: irq_in[4] falls and rises again while SERVICE on 4 -> pending[4]=1, re-requested after eret+GAP_CYCLES. Edge on 4 in the exact ack cycle -> pending[4] remains 1.
- Spurious handshake: ack in IDLE and eret in REQ -> no state change, pending unchanged.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
package irq_arbiter_pkg;

  localparam int IRQ_DEFAULT_N = 8;

  // 2-bit FSM encodings.
  typedef enum logic [1:0] {
    IRQ_STATE_IDLE    = 2'd0,
    IRQ_STATE_REQ     = 2'd1,
    IRQ_STATE_SERVICE = 2'd2,
    IRQ_STATE_GAP     = 2'd3
  } irq_state_e;

  // Index of the lowest set bit (bit 0 wins); 0 when nothing is set.
  // Callers only use the result when the vector is non-zero. Supports up to
  // 32 lines.
  function automatic int lowest_idx(input logic [31:0] v);
    lowest_idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_idx = i;
    end
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Bus between the interrupt arbiter and its environment (lines, mask port,
// cp0 handshake). The master side drives lines/handshake; the arbiter is the
// slave.
interface irq_arbiter_if
  import irq_arbiter_pkg::*;
#(
  parameter int N_IRQ = IRQ_DEFAULT_N
) ();

  localparam int IW = $clog2(N_IRQ);

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             ack;
  logic             eret;
  logic [N_IRQ-1:0] hardware_interrupt;
  logic [IW-1:0]    irq_id;
  logic             busy;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] irq_mask;

  modport master (
    output irq_in, mask_we, mask_wdata, ack, eret,
    input  hardware_interrupt, irq_id, busy, pending, irq_mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, ack, eret,
    output hardware_interrupt, irq_id, busy, pending, irq_mask
  );

endinterface

// File: rtl/irq_arbiter_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a rising
// edge detector. edge_o is a single-cycle pulse in the clk domain.
module irq_arbiter_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the raw line through the chain and remember the previous output.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A level held high yields only one pulse.
  assign edge_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt controller in front of cp0: per-line synchronisers latch rising
// edges into pending, a mask selects eligible lines, the lowest eligible
// index is presented one-hot to cp0 and held through ack until eret, then a
// short idle gap is enforced before the next request.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_IRQ       = IRQ_DEFAULT_N,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            clr,
  irq_arbiter_if.slave    bus
);

  localparam int IW = $clog2(N_IRQ);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] hw_q, hw_d;
  logic [IW-1:0]    id_q, id_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [N_IRQ-1:0] edge_vec;
  logic [N_IRQ-1:0] eligible;
  logic [IW-1:0]    win;
  logic             ack_take;

  // One synchroniser + edge detector per line.
  genvar g;
  generate
    for (g = 0; g < N_IRQ; g++) begin : g_sync
      irq_arbiter_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .clr     (clr),
        .async_i (bus.irq_in[g]),
        .edge_o  (edge_vec[g])
      );
    end
  endgenerate

  // Fixed priority: lowest eligible index wins.
  assign eligible = pending_q & mask_q;
  assign win      = IW'(lowest_idx(32'(eligible)));

  // Next-state logic. The request vector is registered so that it appears
  // the cycle after the IDLE->REQ decision and drops at the same edge that
  // leaves REQ. Ack beats a simultaneous mask-off; no preemption in REQ.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    hw_d     = hw_q;
    gap_d    = gap_q;
    ack_take = 1'b0;
    unique case (state_q)
      IRQ_STATE_IDLE: begin
        if (eligible != '0 && gap_q == '0) begin
          state_d = IRQ_STATE_REQ;
          id_d    = win;
          hw_d    = N_IRQ'(1) << win;
        end
      end
      IRQ_STATE_REQ: begin
        if (bus.ack) begin
          ack_take = 1'b1;
          state_d  = IRQ_STATE_SERVICE;
          hw_d     = '0;
        end else if (!mask_q[id_q]) begin
          // Withdrawn: the line stays pending for a later attempt.
          state_d = IRQ_STATE_IDLE;
          hw_d    = '0;
        end
      end
      IRQ_STATE_SERVICE: begin
        if (bus.eret) begin
          if (GAP_CYCLES == 0) begin
            state_d = IRQ_STATE_IDLE;
          end else begin
            state_d = IRQ_STATE_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      IRQ_STATE_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = IRQ_STATE_IDLE;
      end
      default: state_d = IRQ_STATE_IDLE;
    endcase
  end

  // Pending: ack clears the serviced bit, but a fresh edge on the same line
  // in that cycle keeps it set. Edges on an already-pending line are merged.
  always_comb begin
    pending_d = (pending_q & ~(ack_take ? (N_IRQ'(1) << id_q) : '0)) | edge_vec;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // State register; clr aborts any in-flight service immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IRQ_STATE_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      hw_q      <= '0;
      id_q      <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      hw_q      <= hw_d;
      id_q      <= id_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.hardware_interrupt = hw_q;
  assign bus.irq_id             = id_q;
  assign bus.busy               = (state_q == IRQ_STATE_REQ) || (state_q == IRQ_STATE_SERVICE);
  assign bus.pending            = pending_q;
  assign bus.irq_mask           = mask_q;

endmodule
